alu_ctrl_fsm: RTL
=================

Name: alu_ctrl_fsm

Overview:
Multi-cycle control unit for the 8-bit datapath. It sits on the other side of the ALU's control interface. It fetches 16-bit instructions, decodes them and drives ALU_con. It consumes the ALU's Zero output and uses it to write back results and resolve branches. It owns the PC, the instruction register and a latched Z flag.

Parameters:
PC_W, 8, program counter and instruction address width; wraps modulo 2^PC_W
INSTR_W, 16, instruction width; field layout below is fixed for 16
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address, equal to pc
imem_ack  in  1  fetch complete; imem_rdata valid in the same cycle
imem_rdata  in  INSTR_W  fetched instruction
ALU_con  out  2  ALU operation select: 00 load-imm, 01 add, 11 jump
Zero  in  1  ALU result-is-zero flag
imm  out  8  immediate/target field to ALU B, equal to ir[7:0]
rs_addr  out  2  source register index, equal to ir[11:10]
rd_addr  out  2  destination register index, equal to ir[13:12]
reg_we  out  1  register-file write strobe, one cycle
pc  out  PC_W  current PC
z_flag  out  1  latched Zero from the last LI/ADD

Behaviour:
- Instruction fields: op = ir[15:14], rd = ir[13:12], rs = ir[11:10], imm = ir[7:0]; ir[9:8] are ignored.
- Opcodes:
  - 00 LI: rd <= imm.
  - 01 ADD: rd <= rs + rs, mod 256.
  - 10 BEQZ: if z_flag, pc <= imm; else pc+1.
  - 11 JMP: pc <= imm.
- States: FETCH, DECODE, EXECUTE, WRITEBACK.
- FETCH:
  - imem_req = 1 and imem_addr = pc.
  - Stays in FETCH until imem_ack.
  - On ack, ir <= imem_rdata and the FSM goes to DECODE.
  - imem_req deasserts the cycle after ack.
- DECODE (1 cycle):
  - ALU_con is registered: LI→00, ADD→01, BEQZ/JMP→11.
  - ALU_con is held constant through WRITEBACK.
- EXECUTE (1 cycle):
  - JMP: pc <= imm, then FETCH.
  - BEQZ: pc <= z_flag ? imm : pc+1, then FETCH.
  - LI/ADD: go to WRITEBACK.
- WRITEBACK (1 cycle, LI/ADD only):
  - reg_we = 1.
  - z_flag <= Zero, sampled in this cycle.
  - pc <= pc+1, then FETCH.
- Latency with zero-wait memory (ack in first FETCH cycle): LI/ADD = 4 cycles per instruction; branches = 3.
- Branches never update z_flag and never assert reg_we.
- Reset values:
  - state = FETCH, pc = RESET_PC, ir = 0.
  - ALU_con = 00, z_flag = 0, reg_we = 0.
  - imem_req = 1, since FETCH is combinational on state.
- Boundary conditions:
  - PC wrap: pc = 2^PC_W−1 followed by +1 gives 0.
  - imem_ack outside FETCH is ignored.
  - imem_ack held high: one fetch per FETCH entry.
  - Reset mid-operation: all registers return to reset values immediately. Any in-flight fetch is abandoned and a pending reg_we is suppressed. The memory must tolerate a dropped request.
  - JMP to own address: loops forever, 3 cycles per iteration. No hang detection.

Optional Feature:
Macro ALU_CTRL_SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit).
  - The FSM waits in FETCH with imem_req = 0 until step is high for one cycle, then requests.
  - A step pulse arriving while not in FETCH is latched in a 1-bit pending register; the pending register is cleared on reset.
- Undefined:
  - No step port; fetch begins immediately on entering FETCH.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - state enum;
  - opcode constants OP_LI, OP_ADD, OP_BEQZ, OP_JMP;
  - ALU_con encodings ALUC_LI = 00, ALUC_ADD = 01, ALUC_JMP = 11;
  - field bit positions.
- One natural sub-module: alu_ctrl_decode, combinational op→ALU_con/is_branch/writes_rd. The FSM stays in the top.

Test Plan:
- LI chain, zero-wait memory:
  - Stimulus: program LI r1,0x05; ADD r2,r1 with ALU model.
  - Response: reg_we pulses on cycles 4 and 8; ALU_con sequence 00 then 01.
  - Response: z_flag = 0 after each; pc = 2.
- Zero flag plus branch:
  - Stimulus: LI r0,0x00; BEQZ 0x10.
  - Response: z_flag = 1 after LI; pc = 0x10 after BEQZ.
  - Stimulus repeated with LI r0,0x80; ADD r0,r0 (0x00 mod 256); BEQZ 0x10.
  - Response: branch taken.
- Not taken and JMP:
  - Stimulus: LI r0,0x01; BEQZ 0x20; JMP 0x00.
  - Response: pc sequence 0,1,2,0; reg_we never high during BEQZ/JMP.
- Wait states:
  - Stimulus: imem_ack delayed 3 cycles.
  - Response: imem_req held with a stable imem_addr for all 4 FETCH cycles; ir captured only on ack.
- Wrap and reset:
  - Stimulus: pc = 0xFF executing LI.
  - Response: next pc = 0x00.
  - Stimulus: assert rst during WRITEBACK.
  - Response: reg_we = 0 in that cycle; pc = RESET_PC; state = FETCH.
- ALU_CTRL_SINGLE_STEP_EN:
  - Stimulus: no step pulse.
  - Response: imem_req stays 0 indefinitely.
  - Stimulus: one step pulse.
  - Response: exactly one instruction completes.
  - Stimulus: step pulse during EXECUTE.
  - Response: the next fetch issues immediately on entering FETCH.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control unit: FSM states, opcodes,
// ALU_con encodings and instruction field positions.
package alu_ctrl_pkg;

    // Field widths
    localparam int unsigned OP_W   = 2;
    localparam int unsigned REG_W  = 2;
    localparam int unsigned IMM_W  = 8;
    localparam int unsigned ALUC_W = 2;

    // Instruction field bit positions (16-bit layout)
    localparam int unsigned OP_MSB   = 15;
    localparam int unsigned OP_LSB   = 14;
    localparam int unsigned RD_MSB   = 13;
    localparam int unsigned RD_LSB   = 12;
    localparam int unsigned RS_MSB   = 11;
    localparam int unsigned RS_LSB   = 10;
    localparam int unsigned RSVD_MSB = 9;
    localparam int unsigned RSVD_LSB = 8;
    localparam int unsigned IMM_MSB  = 7;
    localparam int unsigned IMM_LSB  = 0;

    // Opcodes
    localparam logic [OP_W-1:0] OP_LI   = 2'b00;
    localparam logic [OP_W-1:0] OP_ADD  = 2'b01;
    localparam logic [OP_W-1:0] OP_BEQZ = 2'b10;
    localparam logic [OP_W-1:0] OP_JMP  = 2'b11;

    // ALU_con encodings
    localparam logic [ALUC_W-1:0] ALUC_LI  = 2'b00;
    localparam logic [ALUC_W-1:0] ALUC_ADD = 2'b01;
    localparam logic [ALUC_W-1:0] ALUC_JMP = 2'b11;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_DECODE    = 2'd1,
        ST_EXECUTE   = 2'd2,
        ST_WRITEBACK = 2'd3
    } state_t;

    // Instruction word as seen on the fetch bus
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs;
        logic [1:0]       rsvd;
        logic [IMM_W-1:0] imm;
    } instr_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode decoder: ALU operation select and instruction class.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    output logic [ALUC_W-1:0] alu_con_c,
    output logic              is_branch_c,
    output logic              writes_rd_c
);

    // Map opcode to ALU select and class flags
    always_comb begin
        alu_con_c   = ALUC_LI;
        is_branch_c = 1'b0;
        writes_rd_c = 1'b0;
        case (op)
            OP_LI: begin
                writes_rd_c = 1'b1;
            end
            OP_ADD: begin
                alu_con_c   = ALUC_ADD;
                writes_rd_c = 1'b1;
            end
            OP_BEQZ, OP_JMP: begin
                alu_con_c   = ALUC_JMP;
                is_branch_c = 1'b1;
            end
            default: begin
                alu_con_c = ALUC_LI;
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle control unit: fetches 16-bit instructions, drives ALU_con,
// writes back LI/ADD results and resolves BEQZ/JMP. Owns pc, ir and z_flag.
// Optional build macro ALU_CTRL_SINGLE_STEP_EN adds a step input that gates
// each fetch on a (latched) step pulse.
module alu_ctrl_fsm
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
`ifdef ALU_CTRL_SINGLE_STEP_EN
    input  logic               step,
`endif
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ALUC_W-1:0]  ALU_con,
    input  logic               Zero,
    output logic [IMM_W-1:0]   imm,
    output logic [REG_W-1:0]   rs_addr,
    output logic [REG_W-1:0]   rd_addr,
    output logic               reg_we,
    output logic [PC_W-1:0]    pc,
    output logic               z_flag
);

    state_t              state;
    state_t              state_d;
    logic [INSTR_W-1:0]  ir;
    logic [INSTR_W-1:0]  ir_d;
    logic [PC_W-1:0]     pc_d;
    logic [ALUC_W-1:0]   alu_con_d;
    logic                z_flag_d;
    logic                reg_we_d;
    logic [OP_W-1:0]     op;
    logic [ALUC_W-1:0]   dec_alu_con;
    logic                dec_is_branch;
    logic                dec_writes_rd;
    logic                fetch_go;
    logic                unused_rsvd;

    // Instruction fields straight from the instruction register
    assign op          = ir[OP_MSB:OP_LSB];
    assign rd_addr     = ir[RD_MSB:RD_LSB];
    assign rs_addr     = ir[RS_MSB:RS_LSB];
    assign imm         = ir[IMM_MSB:IMM_LSB];
    assign unused_rsvd = ^ir[RSVD_MSB:RSVD_LSB];

    // Fetch request is a pure decode of FETCH (plus the step gate when built in)
    assign imem_req  = (state == ST_FETCH) && fetch_go;
    assign imem_addr = pc;

    alu_ctrl_decode u_decode (
        .op          (op),
        .alu_con_c   (dec_alu_con),
        .is_branch_c (dec_is_branch),
        .writes_rd_c (dec_writes_rd)
    );

`ifdef ALU_CTRL_SINGLE_STEP_EN
    logic step_pending;
    logic step_pending_d;

    // Step pulse is held until a fetch handshake consumes it
    always_comb begin
        step_pending_d = step_pending;
        if ((state == ST_FETCH) && step_pending && imem_ack) begin
            step_pending_d = 1'b0;
        end
        if (step) begin
            step_pending_d = 1'b1;
        end
    end

    // Step pending register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_pending <= 1'b0;
        end else begin
            step_pending <= step_pending_d;
        end
    end

    assign fetch_go = step_pending;
`else
    assign fetch_go = 1'b1;
`endif

    // Next-state and next-register logic
    always_comb begin
        state_d   = state;
        ir_d      = ir;
        pc_d      = pc;
        alu_con_d = ALU_con;
        z_flag_d  = z_flag;
        reg_we_d  = 1'b0;
        case (state)
            ST_FETCH: begin
                if (fetch_go && imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_con_d = dec_alu_con;
                state_d   = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (dec_is_branch) begin
                    state_d = ST_FETCH;
                    if ((op == OP_BEQZ) && !z_flag) begin
                        pc_d = pc + PC_W'(1);
                    end else begin
                        pc_d = PC_W'(imm);
                    end
                end else if (dec_writes_rd) begin
                    state_d  = ST_WRITEBACK;
                    reg_we_d = 1'b1;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_WRITEBACK: begin
                z_flag_d = Zero;
                pc_d     = pc + PC_W'(1);
                state_d  = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_FETCH;
            ir      <= '0;
            pc      <= PC_W'(RESET_PC);
            ALU_con <= ALUC_LI;
            z_flag  <= 1'b0;
            reg_we  <= 1'b0;
        end else begin
            state   <= state_d;
            ir      <= ir_d;
            pc      <= pc_d;
            ALU_con <= alu_con_d;
            z_flag  <= z_flag_d;
            reg_we  <= reg_we_d;
        end
    end

endmodule
